// File: rtl/y_adapt_binarize.sv
// rtl/y_adapt_binarize.sv - adaptive 1-bit binarizer thresholded on the previous frame's mean luminance
// Optional feature macro: BIN_THRESH_IIR_EN (threshold smoothed by a 1/2 IIR instead of direct replacement)
module y_adapt_binarize #(
    parameter logic [9:0] IMG_HDISP     = 10'd640,
    parameter logic [9:0] IMG_VDISP     = 10'd480,
    parameter logic [7:0] THRESH_INIT   = 8'd128,
    parameter logic [7:0] THRESH_OFFSET = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_Y,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic       post_img_Bit,
    output logic [7:0] frame_mean,
    output logic [7:0] thresh,
    output logic       frame_done,
    output logic       pix_count_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_DIVIDE = 2'd2;
    localparam logic [1:0] S_UPDATE = 2'd3;

    localparam logic [19:0] FRAME_PIX = {10'd0, IMG_HDISP} * {10'd0, IMG_VDISP};
    localparam logic [18:0] CNT_MAX   = '1;
    localparam logic [4:0]  DIV_LAST  = 5'd26;

    logic [1:0]  state;
    logic        vs_d;
    logic [26:0] sum;
    logic [18:0] cnt;
    logic [26:0] dvd;
    logic [18:0] rem;
    logic [4:0]  div_cnt;

    logic        pix_ok;
    logic        vs_rise;
    logic        vs_fall;
    logic [26:0] sum_start;
    logic [18:0] cnt_start;

    assign pix_ok    = per_frame_vsync & per_frame_href & per_frame_clken;
    assign vs_rise   = per_frame_vsync & ~vs_d;
    assign vs_fall   = ~per_frame_vsync & vs_d;
    assign sum_start = pix_ok ? 27'(per_img_Y) : 27'd0;
    assign cnt_start = pix_ok ? 19'd1 : 19'd0;

    // Restoring divider: dvd shifts out dividend bits MSB first and fills with quotient bits.
    logic [19:0] rem_sh;
    logic [20:0] rem_diff;
    logic        q_bit;

    assign rem_sh   = {rem, dvd[26]};
    assign rem_diff = {1'b0, rem_sh} - {2'b00, cnt};
    assign q_bit    = ~rem_diff[20];

    logic [7:0] q;
    logic [8:0] q_off;
    logic [7:0] q_sat;
    logic [7:0] thresh_nxt;

    assign q     = dvd[7:0];
    assign q_off = {1'b0, q} + {1'b0, THRESH_OFFSET};
    assign q_sat = q_off[8] ? 8'hFF : q_off[7:0];

`ifdef BIN_THRESH_IIR_EN
    logic [8:0] iir_sum;
    assign iir_sum    = {1'b0, thresh} + {1'b0, q_sat} + 9'd1;
    assign thresh_nxt = 8'(iir_sum >> 1);
`else
    assign thresh_nxt = q_sat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Treat vsync as already high so a reset released mid-frame is not taken as a frame start.
            vs_d             <= 1'b1;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_Bit     <= 1'b0;
            state            <= S_IDLE;
            sum              <= '0;
            cnt              <= '0;
            dvd              <= '0;
            rem              <= '0;
            div_cnt          <= '0;
            frame_mean       <= '0;
            thresh           <= THRESH_INIT;
            frame_done       <= 1'b0;
            pix_count_err    <= 1'b0;
        end else begin
            vs_d             <= per_frame_vsync;
            post_frame_vsync <= per_frame_vsync;
            post_frame_href  <= per_frame_href;
            post_frame_clken <= per_frame_clken;
            post_img_Bit     <= per_frame_href & (per_img_Y >= thresh);
            frame_done       <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (vs_rise) begin
                        sum   <= sum_start;
                        cnt   <= cnt_start;
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (vs_fall) begin
                        dvd     <= (cnt == '0) ? 27'd0 : sum;
                        rem     <= '0;
                        div_cnt <= '0;
                        state   <= (cnt == '0) ? S_UPDATE : S_DIVIDE;
                    end else if (pix_ok) begin
                        sum <= sum + 27'(per_img_Y);
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 19'd1;
                        end
                    end
                end
                S_DIVIDE: begin
                    if (vs_rise) begin
                        sum   <= sum_start;
                        cnt   <= cnt_start;
                        state <= S_ACCUM;
                    end else begin
                        dvd     <= {dvd[25:0], q_bit};
                        rem     <= q_bit ? 19'(rem_diff) : 19'(rem_sh);
                        div_cnt <= div_cnt + 5'd1;
                        if (div_cnt == DIV_LAST) begin
                            state <= S_UPDATE;
                        end
                    end
                end
                S_UPDATE: begin
                    frame_mean    <= q;
                    pix_count_err <= ({1'b0, cnt} != FRAME_PIX);
                    frame_done    <= 1'b1;
                    // An empty frame carries no information, so the threshold is left alone.
                    if (cnt != '0) begin
                        thresh <= thresh_nxt;
                    end
                    if (vs_rise) begin
                        sum   <= sum_start;
                        cnt   <= cnt_start;
                        state <= S_ACCUM;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_y_adapt_binarize.sv
// tb/tb_y_adapt_binarize.sv - directed self-checking bench for y_adapt_binarize (4x2 frames)
module tb_y_adapt_binarize;

`ifdef BIN_THRESH_IIR_EN
    localparam bit IIR_EN = 1'b1;
`else
    localparam bit IIR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       vsync;
    logic       href;
    logic       clken;
    logic [7:0] y;

    logic       o0_vsync, o0_href, o0_clken, o0_bit, o0_done, o0_err;
    logic [7:0] o0_mean, o0_thresh;
    logic       o1_vsync, o1_href, o1_clken, o1_bit, o1_done, o1_err;
    logic [7:0] o1_mean, o1_thresh;

    int n_chk;
    int n_fail;
    logic [7:0] exp_th0;
    logic [7:0] exp_th1;
    logic [7:0] pix [8];

    y_adapt_binarize #(
        .IMG_HDISP(10'd4), .IMG_VDISP(10'd2), .THRESH_INIT(8'd128), .THRESH_OFFSET(8'd0)
    ) u0 (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken), .per_img_Y(y),
        .post_frame_vsync(o0_vsync), .post_frame_href(o0_href), .post_frame_clken(o0_clken),
        .post_img_Bit(o0_bit), .frame_mean(o0_mean), .thresh(o0_thresh),
        .frame_done(o0_done), .pix_count_err(o0_err)
    );

    y_adapt_binarize #(
        .IMG_HDISP(10'd4), .IMG_VDISP(10'd2), .THRESH_INIT(8'd128), .THRESH_OFFSET(8'd100)
    ) u1 (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken), .per_img_Y(y),
        .post_frame_vsync(o1_vsync), .post_frame_href(o1_href), .post_frame_clken(o1_clken),
        .post_img_Bit(o1_bit), .frame_mean(o1_mean), .thresh(o1_thresh),
        .frame_done(o1_done), .pix_count_err(o1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] next_th(input logic [7:0] old, input logic [7:0] m, input logic [7:0] off);
        int s;
        s = int'(m) + int'(off);
        if (s > 255) s = 255;
        return 8'(IIR_EN ? (int'(old) + s + 1) / 2 : s);
    endfunction

    // One 4x2 frame from pix[]; pixels at index >= n_acc have clken low.
    // abort_after > 0: after the fall, watch that many cycles for no frame_done and return (vsync still low).
    task automatic run_frame(input string tag, input int n_acc, input int done_cyc,
                             input logic [7:0] exp_mean, input logic exp_err, input int abort_after);
        int k;
        vsync = 1'b1; href = 1'b0; clken = 1'b0; y = 8'd0;
        @(negedge clk);
        for (int ln = 0; ln < 2; ln++) begin
            for (int c = 0; c < 4; c++) begin
                href  = 1'b1;
                clken = ((ln * 4 + c) < n_acc);
                y     = pix[ln * 4 + c];
                @(negedge clk);
                chk({tag, "_bit0"}, o0_bit, (y >= exp_th0));
                chk({tag, "_bit1"}, o1_bit, (y >= exp_th1));
                chk({tag, "_hdly"}, {o0_vsync, o0_href, o0_clken}, {2'b11, clken});
            end
            href = 1'b0; clken = 1'b0;
            @(negedge clk);
        end
        vsync = 1'b0;
        if (abort_after > 0) begin
            repeat (abort_after) begin
                @(negedge clk);
                chk({tag, "_nodone"}, o0_done, 1'b0);
            end
            chk({tag, "_th_kept"}, o0_thresh, exp_th0);
        end else begin
            k = 0;
            while (k < 40 && !o0_done) begin
                @(negedge clk);
                k++;
            end
            chk({tag, "_done_lat"}, k, done_cyc);
            chk({tag, "_done1"}, o1_done, 1'b1);
            if (n_acc != 0) begin
                exp_th0 = next_th(exp_th0, exp_mean, 8'd0);
                exp_th1 = next_th(exp_th1, exp_mean, 8'd100);
            end
            chk({tag, "_mean"}, o0_mean, exp_mean);
            chk({tag, "_mean1"}, o1_mean, exp_mean);
            chk({tag, "_err"}, o0_err, exp_err);
            chk({tag, "_th0"}, o0_thresh, exp_th0);
            chk({tag, "_th1"}, o1_thresh, exp_th1);
            @(negedge clk);
            chk({tag, "_pulse"}, o0_done, 1'b0);
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mean"}, o0_mean, 8'd0);
        chk({tag, "_th0"}, o0_thresh, 8'd128);
        chk({tag, "_th1"}, o1_thresh, 8'd128);
        chk({tag, "_done"}, o0_done, 1'b0);
        chk({tag, "_err"}, o0_err, 1'b0);
        chk({tag, "_post"}, {o0_vsync, o0_href, o0_clken, o0_bit}, 4'd0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        exp_th0 = 8'd128; exp_th1 = 8'd128;
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0; y = 8'd0;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // mean 465/8 = 58; IIR from 128 gives 93
        pix = '{8'd0, 8'd255, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
        run_frame("mix", 8, 29, 8'd58, 1'b0, 0);
        chk("mix_th_hand", o0_thresh, IIR_EN ? 32'd93 : 32'd58);

        pix = '{8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200};
        run_frame("flat200", 8, 29, 8'd200, 1'b0, 0);

        // 199/200 straddle the direct threshold; 254 sits below the saturated offset threshold
        pix = '{8'd199, 8'd200, 8'd254, 8'd255, 8'd0, 8'd50, 8'd100, 8'd200};
        run_frame("straddle", 8, 29, 8'd157, 1'b0, 0);

        // 7 accepted pixels: 280/7 = 40
        pix = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd255};
        run_frame("short", 7, 29, 8'd40, 1'b1, 0);

        pix = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
        run_frame("full", 8, 29, 8'd100, 1'b0, 0);

        pix = '{8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50};
        run_frame("abort", 8, 0, 8'd0, 1'b0, 10);
        pix = '{8'd80, 8'd80, 8'd80, 8'd80, 8'd80, 8'd80, 8'd80, 8'd80};
        run_frame("after_abort", 8, 29, 8'd80, 1'b0, 0);

        run_frame("empty", 0, 2, 8'd0, 1'b1, 0);

        pix = '{8'd90, 8'd90, 8'd90, 8'd90, 8'd90, 8'd90, 8'd90, 8'd90};
        run_frame("short90", 7, 29, 8'd90, 1'b1, 0);

        pix = '{8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200};
        run_frame("pre_rst", 8, 0, 8'd0, 1'b0, 10);
        #2 rst_n = 1'b0;
        #1 chk_reset("mid_div_rst");
        exp_th0 = 8'd128; exp_th1 = 8'd128;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame("post_rst", 8, 29, 8'd200, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/y_adapt_binarize.md
# y_adapt_binarize

Adaptive binarization stage downstream of the Sobel enhancement stage. It consumes the enhanced luminance stream (`post_img_Y` plus its frame syncs) and outputs a 1-bit image plus delayed syncs. Each pixel is thresholded against the mean luminance of the previous frame. The mean is computed during vertical blanking with an iterative divider.

## Interface
- `IMG_HDISP`, 10'd640: active pixels per line.
- `IMG_VDISP`, 10'd480: active lines per frame.
- `THRESH_INIT`, 8'd128: threshold after reset.
- `THRESH_OFFSET`, 8'd0: added to the frame mean to form the threshold; the sum saturates at 255.
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `per_frame_vsync` in 1: high while the frame is active.
- `per_frame_href` in 1: line valid.
- `per_frame_clken` in 1: pixel valid strobe.
- `per_img_Y` in 8: enhanced luminance.
- `post_frame_vsync`, `post_frame_href`, `post_frame_clken` out 1: the input syncs delayed 1 cycle.
- `post_img_Bit` out 1: binarized pixel; 1 means Y ≥ threshold.
- `frame_mean` out 8: last computed frame mean.
- `thresh` out 8: threshold currently applied.
- `frame_done` out 1: one-cycle pulse when `frame_mean` and `thresh` update.
- `pix_count_err` out 1: last frame's pixel count ≠ IMG_HDISP×IMG_VDISP. Held until the next `frame_done`.

## Operation
- Reset values:
  - All outputs are 0, except `thresh` = sat(THRESH_INIT) with no offset.
  - Sum, count and divider registers are 0.
  - State is IDLE.
- Pixel accepted: `per_frame_vsync` & `per_frame_href` & `per_frame_clken` sampled high.
- Binarize: `post_img_Bit` <= `per_frame_href` ? (`per_img_Y` ≥ `thresh`) : 0. It always uses the registered `thresh`, including mid-frame.
- Accumulators:
  - `sum` is 27 bits (255×524287 fits).
  - `cnt` is 19 bits and saturates at 2^19−1.
- Edge detection uses a 1-cycle delayed copy `vs_d`.
  - Rise: `per_frame_vsync` & !`vs_d`.
  - Fall: !`per_frame_vsync` & `vs_d`.
- IDLE:
  - On rise: `sum` <= accepted ? Y : 0 and `cnt` <= accepted ? 1 : 0, then go to ACCUM.
  - Reset released with vsync already high: no accumulation until the next rise (no partial frame).
- ACCUM:
  - Each accepted pixel adds Y to `sum` and increments `cnt`.
  - On fall: if `cnt` == 0, go to UPDATE with the mean forced to 0 and the threshold update suppressed. Otherwise go to DIVIDE.
- DIVIDE:
  - Restoring division of `sum` by `cnt`, one quotient bit per cycle, MSB first, 27 cycles.
  - The quotient is ≤ 255 by construction; the low 8 bits are taken.
  - A rise during DIVIDE aborts it: no `frame_done`, outputs unchanged, and the block re-enters ACCUM exactly as from IDLE.
- UPDATE (1 cycle):
  - `frame_mean` <= q.
  - `thresh` <= new threshold (see Configuration), unless the count was 0.
  - `pix_count_err` <= (`cnt` ≠ IMG_HDISP×IMG_VDISP).
  - `frame_done` = 1.
  - Next state: IDLE. A rise on this same cycle is captured as in IDLE.
- An asynchronous reset at any point returns to reset values immediately. The threshold reverts to THRESH_INIT.

## Timing
- Pixel path latency is 1 cycle. `post_img_Bit` aligns with the `post_frame_*` syncs.
- `frame_done` is high on the 29th rising edge after the edge that first samples vsync low (fall detect + 27 divide + update).
- Zero-count frame: `frame_done` occurs 2 cycles after the fall.
- Minimum vertical blanking for a guaranteed update is 29 cycles.
- The new `thresh` applies from the first pixel of the frame after `frame_done`.

## Configuration
- `BIN_THRESH_IIR_EN` defined:
  - `thresh` <= (`thresh` + sat(q+THRESH_OFFSET) + 1) >> 1, computed with a 9-bit sum and rounding.
  - This smooths flicker between frames.
- `BIN_THRESH_IIR_EN` undefined: `thresh` <= sat(q + THRESH_OFFSET), a direct replacement.

## Test plan
- Bench parameters: IMG_HDISP=4, IMG_VDISP=2, offset 0.
- Frame of all Y=200 (8 px), followed by ≥29 blanking cycles:
  - `frame_mean`=200, `thresh`=200, `pix_count_err`=0.
  - Next frame Y=199 gives Bit=0; Y=200 gives Bit=1.
- Frame with values 0,255,10,20,30,40,50,60 (sum 465): mean=58, `thresh`=58.
  - With `BIN_THRESH_IIR_EN` and prior thresh 128: `thresh`=93.
- THRESH_OFFSET=100 with a frame mean of 200: `thresh` saturates to 255. A pixel of Y=254 gives Bit=0.
- Frame with 7 accepted pixels: `pix_count_err`=1, mean is correct over 7. A following 8-pixel frame clears it.
- Vsync re-rises 10 cycles after the fall: no `frame_done`, `thresh` unchanged, and the new frame accumulates correctly.
- Vsync high with no pixels: `frame_done` 2 cycles after the fall, `frame_mean`=0, `thresh` unchanged.
- Reset asserted mid-DIVIDE: all outputs go to reset values and `thresh`=128.
